rr_arb_mux: RTL



---
 rtl/rr_arb_mux_pkg.sv | 12 +
 rtl/rr_arbiter.sv | 80 ++++++++
 rtl/rr_arb_mux.sv | 106 ++++++++++
 3 files changed

// File: rtl/rr_arb_mux_pkg.sv
// Shared constants and helpers for the round-robin arbitrated multiplexer.
package rr_arb_mux_pkg;

    // Largest channel count the arbiter is qualified for.
    localparam int unsigned RR_ARB_MAX_N = 32;

    // Channel index width; a single channel still needs a one-bit index.
    function automatic int unsigned sel_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : rr_arb_mux_pkg

// File: rtl/rr_arbiter.sv
// Round-robin (or, with RR_ARB_MUX_FIXED_PRIO_EN, fixed lowest-index-first)
// request arbiter. Owns the priority pointer; the pointer only moves when the
// caller signals that the granted request actually transferred (adv).
module rr_arbiter #(
    parameter int unsigned N     = 8,
    parameter int unsigned SEL_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    input  logic             adv,
    output logic [N-1:0]     gnt,
    output logic [SEL_W-1:0] gidx,
    output logic             any
);

    // Channel the priority search starts from.
    logic [SEL_W-1:0] start_idx;

`ifdef RR_ARB_MUX_FIXED_PRIO_EN

    // No pointer state: lowest index always wins.
    logic unused_fixed;
    assign unused_fixed = ^{clk, rst_n, adv};
    assign start_idx    = '0;

`else

    logic [SEL_W-1:0] ptr_q, ptr_d;

    // Next pointer: one past the winner, wrapping at N-1 so it never reaches N.
    always_comb begin
        ptr_d = ptr_q;
        if (adv) begin
            ptr_d = (gidx == SEL_W'(N - 1)) ? '0 : gidx + 1'b1;
        end
    end

    // Pointer register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign start_idx = ptr_q;

    ptr_in_range_a : assert property (@(posedge clk) disable iff (!rst_n)
        ptr_q < SEL_W'(N - 1) || ptr_q == SEL_W'(N - 1));

`endif

    // Candidate index for each search step; one extra bit absorbs the wrap.
    logic [SEL_W:0] cand;

    // Search ascending from start_idx, wrapping N-1 -> 0; first requester wins.
    always_comb begin
        gnt  = '0;
        gidx = '0;
        any  = 1'b0;
        cand = '0;
        for (int unsigned i = 0; i < N; i++) begin
            cand = {1'b0, start_idx} + (SEL_W + 1)'(i);
            if (cand >= (SEL_W + 1)'(N)) begin
                cand = cand - (SEL_W + 1)'(N);
            end
            if (!any && req[cand[SEL_W-1:0]]) begin
                any                   = 1'b1;
                gnt[cand[SEL_W-1:0]]  = 1'b1;
                gidx                  = cand[SEL_W-1:0];
            end
        end
    end

    gnt_onehot_a : assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(gnt) && (any == |gnt));

endmodule : rr_arbiter

// File: rtl/rr_arb_mux.sv
// N-channel valid/ready multiplexer with an internal arbiter and one output
// register stage (one cycle latency, full throughput).
// Build option: define RR_ARB_MUX_FIXED_PRIO_EN for fixed lowest-index-first
// priority instead of round-robin; port behaviour is otherwise identical.
module rr_arb_mux
    import rr_arb_mux_pkg::*;
#(
    parameter  int unsigned N     = 8,
    parameter  int unsigned WIDTH = 8,
    localparam int unsigned SEL_W = sel_width(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [SEL_W-1:0]   out_sel,
    output logic               out_valid,
    input  logic               out_ready
);

    if (N < 1 || N > RR_ARB_MAX_N) begin : gen_bad_n
        $error("rr_arb_mux: N out of supported range");
    end

    logic [N-1:0]     gnt;
    logic [SEL_W-1:0] gidx;
    logic             any;
    logic             load;
    logic             xfer;
    logic [WIDTH-1:0] sel_data;

    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SEL_W-1:0] out_sel_q, out_sel_d;
    logic             out_valid_q, out_valid_d;

    // Output register may take a word when empty or being drained this cycle.
    // rst_n gating keeps in_ready low while reset is asserted.
    assign load     = (!out_valid_q || out_ready) && rst_n;
    assign xfer     = load && any;
    assign in_ready = gnt & {N{load}};

    rr_arbiter #(
        .N     (N),
        .SEL_W (SEL_W)
    ) u_arbiter (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (in_valid),
        .adv   (xfer),
        .gnt   (gnt),
        .gidx  (gidx),
        .any   (any)
    );

    // One-hot AND-OR select of the granted channel's data.
    always_comb begin
        sel_data = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (gnt[i]) begin
                sel_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Next state of the output stage: capture on transfer, empty on idle load.
    always_comb begin
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        out_valid_d = out_valid_q;
        if (load) begin
            if (any) begin
                out_data_d  = sel_data;
                out_sel_d   = gidx;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    // Output register; reset drops any held word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_sel_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;
    assign out_valid = out_valid_q;

    in_ready_onehot_a : assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(in_ready));

    out_hold_a : assert property (@(posedge clk) disable iff (!rst_n)
        (out_valid && !out_ready) |=> (out_valid && $stable(out_data) && $stable(out_sel)));

endmodule : rr_arb_mux
